// File: rtl/rr_mux_reg.sv
// N-channel valid/ready multiplexer with a single-entry registered output.
// The channel is picked by a round-robin arbiter (MODE 0) or by the external sel input (MODE 1).
module rr_mux_reg #(
  parameter int WIDTH    = 16,
  parameter int CHANNELS = 4,
  parameter int MODE     = 0,
  localparam int SELW    = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_valid,
  output logic [CHANNELS-1:0]       in_ready,
  input  logic [SELW-1:0]           sel,
  output logic [WIDTH-1:0]          out_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [SELW-1:0]           out_chan
);

  logic [CHANNELS-1:0] grant;
  logic [SELW-1:0]     gnt_idx;
  logic                any_grant;
  logic                load_ok;
  logic                in_xfer;
  logic [WIDTH-1:0]    gnt_data;
  int                  idx;

  logic [WIDTH-1:0]    out_data_q,  out_data_d;
  logic                out_valid_q, out_valid_d;
  logic [SELW-1:0]     out_chan_q,  out_chan_d;
  logic [SELW-1:0]     last_q,      last_d;

  // Grant: depends only on in_valid, sel and the round-robin pointer.
  always_comb begin
    grant     = '0;
    gnt_idx   = '0;
    any_grant = 1'b0;
    idx       = 0;
    if (MODE == 0) begin
      for (int i = 1; i <= CHANNELS; i++) begin
        idx = (int'(last_q) + i) % CHANNELS;
        if (!any_grant && in_valid[idx]) begin
          any_grant  = 1'b1;
          grant[idx] = 1'b1;
          gnt_idx    = SELW'(idx);
        end
      end
    end else if (int'(sel) < CHANNELS) begin
      if (in_valid[sel]) begin
        any_grant  = 1'b1;
        grant[sel] = 1'b1;
        gnt_idx    = sel;
      end
    end
  end

  always_comb begin
    gnt_data = in_data[int'(gnt_idx)*WIDTH +: WIDTH];
    load_ok  = !out_valid_q || out_ready;
    in_ready = grant & {CHANNELS{load_ok}};
    in_xfer  = any_grant && load_ok;
  end

  always_comb begin
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_chan_d  = out_chan_q;
    last_d      = last_q;
    if (in_xfer) begin
      out_data_d  = gnt_data;
      out_chan_d  = gnt_idx;
      out_valid_d = 1'b1;
      last_d      = gnt_idx;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // Output register stage; the pointer resets so channel 0 is searched first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_chan_q  <= '0;
      last_q      <= SELW'(CHANNELS - 1);
    end else begin
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_chan_q  <= out_chan_d;
      last_q      <= last_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_chan  = out_chan_q;

endmodule
